// File: rtl/phys_reg_free_list.sv
`default_nettype none
// ============================================================================
// Module  : phys_reg_free_list
// Purpose : Circular free list of physical register indices with speculative
//           and committed read pointers for single-cycle flush recovery.
// Revision: 1.0 - initial release
// ============================================================================
module phys_reg_free_list #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int DEPTH    = NUM_PHYS - NUM_ARCH,
  localparam int c_preg_w = $clog2(NUM_PHYS),
  localparam int c_idx_w  = $clog2(DEPTH),
  localparam int c_ptr_w  = c_idx_w + 1,
  localparam int c_cnt_w  = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_alloc_req,
  output logic                o_alloc_valid,
  output logic [c_preg_w-1:0] o_alloc_preg,
  input  logic                i_commit_alloc,
  input  logic                i_release_en,
  input  logic [c_preg_w-1:0] i_release_preg,
  input  logic                i_flush,
  output logic [c_cnt_w-1:0]  o_free_count,
  output logic                o_err
);

  logic [c_preg_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]  r_spec_head;
  logic [c_ptr_w-1:0]  r_commit_head;
  logic [c_ptr_w-1:0]  r_tail;
  logic [c_cnt_w-1:0]  r_free_count;
  logic                r_err;

  logic                w_full;
  logic                w_grant;
  logic                w_rel_req;
  logic                w_rel_do;
  logic                w_rel_drop;
  logic                w_outstanding;
  logic                w_commit_do;
  logic                w_commit_bad;
  logic [c_ptr_w-1:0]  w_commit_nxt;
  logic [c_ptr_w-1:0]  w_spec_nxt;
  logic [c_ptr_w-1:0]  w_tail_nxt;
  logic [c_ptr_w-1:0]  w_count_nxt;

  // Full: same slot index but the tail has lapped the head once.
  assign w_full = (r_tail[c_idx_w-1:0] == r_spec_head[c_idx_w-1:0]) &&
                  (r_tail[c_idx_w] != r_spec_head[c_idx_w]);

  assign o_alloc_valid = (r_free_count != '0);
  assign o_alloc_preg  = r_mem[r_spec_head[c_idx_w-1:0]];
  assign o_free_count  = r_free_count;
  assign o_err         = r_err;

  assign w_grant       = i_alloc_req && o_alloc_valid && !i_flush;
  assign w_rel_req     = i_release_en && (i_release_preg != '0);
  assign w_rel_do      = w_rel_req && !w_full;
  assign w_rel_drop    = w_rel_req && w_full;
  assign w_outstanding = (r_commit_head != r_spec_head);
  assign w_commit_do   = i_commit_alloc && w_outstanding;
  assign w_commit_bad  = i_commit_alloc && !w_outstanding;

  always_comb begin
    w_commit_nxt = r_commit_head;
    w_spec_nxt   = r_spec_head;
    w_tail_nxt   = r_tail;
    if (w_commit_do) begin
      w_commit_nxt = r_commit_head + c_ptr_w'(1);
    end
    // Flush rewinds to the commit point including this cycle's commit.
    if (i_flush) begin
      w_spec_nxt = w_commit_nxt;
    end else if (w_grant) begin
      w_spec_nxt = r_spec_head + c_ptr_w'(1);
    end
    if (w_rel_do) begin
      w_tail_nxt = r_tail + c_ptr_w'(1);
    end
    w_count_nxt = w_tail_nxt - w_spec_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= c_preg_w'(NUM_ARCH + i);
      end
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= c_ptr_w'(DEPTH);
      r_free_count  <= c_cnt_w'(DEPTH);
      r_err         <= 1'b0;
    end else begin
      if (w_rel_do) begin
        r_mem[r_tail[c_idx_w-1:0]] <= i_release_preg;
      end
      r_spec_head   <= w_spec_nxt;
      r_commit_head <= w_commit_nxt;
      r_tail        <= w_tail_nxt;
      r_free_count  <= c_cnt_w'(w_count_nxt);
      if (w_rel_drop || w_commit_bad) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phys_reg_free_list.sv
`default_nettype none
// ============================================================================
// Module  : tb_phys_reg_free_list
// Purpose : Directed self-checking bench for the physical register free list.
// Revision: 1.0 - initial release
// ============================================================================
module tb_phys_reg_free_list;

  logic       clk;
  logic       rst_n;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_preg;
  logic       commit_alloc;
  logic       release_en;
  logic [5:0] release_preg;
  logic       flush;
  logic [5:0] free_count;
  logic       err;

  int checks = 0;
  int errors = 0;

  phys_reg_free_list dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_alloc_req    (alloc_req),
    .o_alloc_valid  (alloc_valid),
    .o_alloc_preg   (alloc_preg),
    .i_commit_alloc (commit_alloc),
    .i_release_en   (release_en),
    .i_release_preg (release_preg),
    .i_flush        (flush),
    .o_free_count   (free_count),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    alloc_req    = 1'b0;
    commit_alloc = 1'b0;
    release_en   = 1'b0;
    release_preg = 6'd0;
    flush        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d expected 32", free_count); end
    checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %0d expected 1", alloc_valid); end
    checks++; if (alloc_preg !== 6'd32) begin errors++; $display("FAIL reset_preg: got %0d expected 32", alloc_preg); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      alloc_req = 1'b1;
      checks++; if (alloc_preg !== 6'(32 + i)) begin errors++; $display("FAIL fill_preg[%0d]: got %0d expected %0d", i, alloc_preg, 32 + i); end
      checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL fill_valid[%0d]: got %0d expected 1", i, alloc_valid); end
      step();
    end
    alloc_req = 1'b0;
    checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL fill_count: got %0d expected 0", free_count); end
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL fill_empty_valid: got %0d expected 0", alloc_valid); end
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
    checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL empty_req_count: got %0d expected 0", free_count); end
    checks++; if (alloc_preg !== 6'd32) begin errors++; $display("FAIL empty_req_preg: got %0d expected 32", alloc_preg); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL empty_req_err: got %0d expected 0", err); end
  endtask

  task automatic test_release_empty();
    alloc_req    = 1'b1;
    release_en   = 1'b1;
    release_preg = 6'd40;
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL rel_empty_valid_same: got %0d expected 0", alloc_valid); end
    step();
    idle();
    checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL rel_empty_valid: got %0d expected 1", alloc_valid); end
    checks++; if (alloc_preg !== 6'd40) begin errors++; $display("FAIL rel_empty_preg: got %0d expected 40", alloc_preg); end
    checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL rel_empty_count: got %0d expected 1", free_count); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 1'b1;
    repeat (5) step();
    alloc_req = 1'b0;
    commit_alloc = 1'b1;
    repeat (2) step();
    commit_alloc = 1'b0;
    checks++; if (free_count !== 6'd27) begin errors++; $display("FAIL flush_pre_count: got %0d expected 27", free_count); end
    flush     = 1'b1;
    alloc_req = 1'b1;
    step();
    idle();
    checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL flush_count: got %0d expected 30", free_count); end
    checks++; if (alloc_preg !== 6'd34) begin errors++; $display("FAIL flush_preg: got %0d expected 34", alloc_preg); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err: got %0d expected 0", err); end
  endtask

  task automatic test_flush_commit();
    do_reset();
    alloc_req = 1'b1;
    repeat (3) step();
    alloc_req = 1'b0;
    commit_alloc = 1'b1;
    step();
    flush = 1'b1;
    step();
    idle();
    checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL flush_commit_count: got %0d expected 30", free_count); end
    checks++; if (alloc_preg !== 6'd34) begin errors++; $display("FAIL flush_commit_preg: got %0d expected 34", alloc_preg); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_commit_err: got %0d expected 0", err); end
  endtask

  task automatic test_wrap();
    int q[$];
    int hist[$];
    int exp_v;
    int rel;
    do_reset();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1;
      exp_v = q.pop_front();
      checks++; if (alloc_preg !== 6'(exp_v)) begin errors++; $display("FAIL wrap_pre_preg[%0d]: got %0d expected %0d", i, alloc_preg, exp_v); end
      hist.push_back(exp_v);
      step();
    end
    for (int c = 0; c < 100; c++) begin
      alloc_req = 1'b1;
      exp_v = q.pop_front();
      checks++; if (alloc_preg !== 6'(exp_v)) begin errors++; $display("FAIL wrap_preg[%0d]: got %0d expected %0d", c, alloc_preg, exp_v); end
      rel = hist.pop_front();
      release_en   = 1'b1;
      release_preg = 6'(rel);
      q.push_back(rel);
      hist.push_back(exp_v);
      step();
      checks++; if (free_count !== 6'd28) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 28", c, free_count); end
    end
    idle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %0d expected 0", err); end
  endtask

  task automatic test_errors();
    do_reset();
    release_en   = 1'b1;
    release_preg = 6'd5;
    step();
    idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_rel_err: got %0d expected 1", err); end
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL full_rel_count: got %0d expected 32", free_count); end
    checks++; if (alloc_preg !== 6'd32) begin errors++; $display("FAIL full_rel_preg: got %0d expected 32", alloc_preg); end

    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0d expected 0", err); end
    alloc_req = 1'b1;
    step();
    idle();
    release_en   = 1'b1;
    release_preg = 6'd0;
    step();
    idle();
    checks++; if (free_count !== 6'd31) begin errors++; $display("FAIL zero_rel_count: got %0d expected 31", free_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_rel_err: got %0d expected 0", err); end

    do_reset();
    commit_alloc = 1'b1;
    step();
    idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_commit_err: got %0d expected 1", err); end
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL bad_commit_count: got %0d expected 32", free_count); end
    alloc_req = 1'b1;
    repeat (2) step();
    idle();
    flush = 1'b1;
    step();
    idle();
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL bad_commit_head: got %0d expected 32", free_count); end
    checks++; if (alloc_preg !== 6'd32) begin errors++; $display("FAIL bad_commit_preg: got %0d expected 32", alloc_preg); end

    alloc_req = 1'b1;
    repeat (3) step();
    checks++; if (free_count !== 6'd29) begin errors++; $display("FAIL mid_pre_count: got %0d expected 29", free_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL mid_rst_count: got %0d expected 32", free_count); end
    checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_valid: got %0d expected 1", alloc_valid); end
    checks++; if (alloc_preg !== 6'd32) begin errors++; $display("FAIL mid_rst_preg: got %0d expected 32", alloc_preg); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %0d expected 0", err); end
    idle();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_fill();
    test_release_empty();
    test_flush();
    test_flush_commit();
    test_wrap();
    test_errors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
